vec_issue_queue: RTL and testbench
==================================

VEC_ISSUE_QUEUE -- requirements
Module: vec_issue_queue

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, scalar/instruction width; DEPTH, default 4, queue entries (power of two, at least 2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 inst_valid_i  input  1  scalar core offers an instruction.
REQ-005 inst_i  input  XLEN  offered instruction word.
REQ-006 rs1_i, rs2_i  input  XLEN each  scalar operand values sampled with inst_i.
REQ-007 inst_ready_o  output  1  queue accepts the offer this cycle.
REQ-008 vec_valid_o  output  1  head entry is presented to vec_decode.
REQ-009 vec_inst_o, rs1_o, rs2_o  output  XLEN each  head entry fields.
REQ-010 vec_ready_i  input  1  downstream consumes the head this cycle.
REQ-011 flush_i  input  1  synchronous discard of all entries.
REQ-012 reject_o  output  1  one-cycle pulse: the last accepted offer was non-vector and was dropped.
REQ-013 count_o  output  $clog2(DEPTH)+1  number of valid entries.
REQ-014 cfg_pending_o  output  1  at least one queued entry is a vsetvl/vsetvli/vsetivli.

Function
REQ-015 An offer SHALL be accepted when inst_valid_i && inst_ready_o.
REQ-016 inst_ready_o SHALL be high when count_o < DEPTH, or when count_o == DEPTH and vec_ready_i is high (simultaneous pop frees a slot).
REQ-017 An accepted word with inst_i[6:0] != 7'h57 SHALL NOT be enqueued; reject_o SHALL be high in the following cycle only.
REQ-018 An accepted word with opcode 7'h57 SHALL be written at the tail together with rs1_i and rs2_i.
REQ-019 An entry SHALL be marked as config when inst_i[14:12] == 3'b111.
REQ-020 vec_valid_o SHALL equal (count_o != 0); vec_inst_o, rs1_o and rs2_o SHALL show the head entry and SHALL remain stable while vec_valid_o && !vec_ready_i.
REQ-021 A pop SHALL occur when vec_valid_o && vec_ready_i; vec_ready_i with an empty queue SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL leave count_o unchanged and SHALL preserve order.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; full/empty SHALL be resolved by count_o, not by pointer equality.
REQ-024 Without bypass, latency from acceptance to vec_valid_o SHALL be 1 cycle.
REQ-025 cfg_pending_o SHALL be driven by an internal config counter, incremented on a config push and decremented on a config pop; a simultaneous config push and config pop SHALL leave it unchanged.
REQ-026 A config entry at the head SHALL be presented only when vec_ready_i was high in the previous cycle (one-cycle drain gap). vec_valid_o SHALL be low for that cycle.
REQ-027 flush_i SHALL clear count_o, the pointers, the config counter and reject_o in the next cycle. flush_i SHALL have priority over a same-cycle push or pop, and inst_ready_o SHALL be low while flush_i is high.
REQ-028 Head data of empty or popped entries SHALL be don't-care, but vec_inst_o SHALL read 0 when the queue is empty.

Reset
REQ-029 While reset_n is low: count_o = 0, vec_valid_o = 0, reject_o = 0, cfg_pending_o = 0, pointers = 0, drain flag = 0, and vec_inst_o/rs1_o/rs2_o = 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-031 inst_ready_o SHALL be high from the first edge after reset_n rises.

Configuration
REQ-032 Macro VEC_ISSUE_BYPASS_EN. When defined and the queue is empty with vec_ready_i high, an accepted non-config vector offer SHALL appear on the outputs in the same cycle and be consumed without being enqueued (0-cycle latency).
REQ-033 Without VEC_ISSUE_BYPASS_EN, every instruction SHALL pass through storage (REQ-024).

Structure
REQ-034 Opcode constant V_ARITH (7'h57) and func3 constant CONF (3'b111) SHALL come from the shared vector decode/CSR definitions package; the entry struct {inst, rs1, rs2, is_cfg} SHALL be a typedef there.
REQ-035 Storage SHALL be one sub-module, vec_issue_fifo_mem: DEPTH x entry register array with write port and read port.

Verification
REQ-036 Fill: offer 5 vadd.vv (32'h02208057) with vec_ready_i=0 -> count_o = 4; inst_ready_o = 0 after the fourth acceptance; the fifth offer stalls.
REQ-037 Full with simultaneous pop: at count_o=4, offer plus vec_ready_i=1 -> offer accepted, count_o stays 4, and head order is FIFO-correct.
REQ-038 Reject: offer 32'h00000013 (addi) -> reject_o pulses 1 cycle, count_o unchanged.
REQ-039 Config: push vsetvli (func3=111) behind two arith ops, with vec_ready_i=1 -> cfg_pending_o=1 until its pop; one bubble cycle occurs before it is presented.
REQ-040 Flush and reset: with 3 entries, assert flush_i -> count_o=0 next cycle; with 3 entries, drop reset_n asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/vec_issue_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_issue_queue_pkg : vector decode/CSR constants and queue entry     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vec_issue_queue_pkg;

    localparam int         PKG_XLEN = 32;
    localparam logic [6:0] V_ARITH  = 7'h57;
    localparam logic [2:0] CONF     = 3'b111;

    typedef struct packed {
        logic [PKG_XLEN-1:0] inst;
        logic [PKG_XLEN-1:0] rs1;
        logic [PKG_XLEN-1:0] rs2;
        logic                is_cfg;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/vec_issue_queue_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_issue_fifo_mem : DEPTH x entry register array, 1W / 1R (async rd) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vec_issue_fifo_mem
    import vec_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);

    // Contents are don't-care until written, so the array carries no reset.
    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/vec_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_issue_queue : scalar-to-vector instruction issue FIFO             |
// | Optional macro VEC_ISSUE_BYPASS_EN: 0-cycle bypass when queue empty.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vec_issue_queue
    import vec_issue_queue_pkg::*;
#(
    parameter int XLEN  = PKG_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     inst_valid_i,
    input  logic [XLEN-1:0]          inst_i,
    input  logic [XLEN-1:0]          rs1_i,
    input  logic [XLEN-1:0]          rs2_i,
    output logic                     inst_ready_o,
    output logic                     vec_valid_o,
    output logic [XLEN-1:0]          vec_inst_o,
    output logic [XLEN-1:0]          rs1_o,
    output logic [XLEN-1:0]          rs2_o,
    input  logic                     vec_ready_i,
    input  logic                     flush_i,
    output logic                     reject_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     cfg_pending_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    generate
        if (XLEN != PKG_XLEN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
            $error("vec_issue_queue: XLEN must match package width, DEPTH a power of two >= 2");
        end
    endgenerate

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_cfg_cnt;
    logic             r_reject;
    logic             r_drain;

    entry_t w_head_entry;
    entry_t w_wr_entry;
    logic   w_empty, w_head_cfg, w_q_valid, w_pop;
    logic   w_accept, w_is_vec, w_is_cfg, w_push, w_bypass;

    assign w_empty    = (r_count == '0);
    assign w_head_cfg = !w_empty && w_head_entry.is_cfg;
    // A config head waits for the drain flag, giving a one-cycle bubble.
    assign w_q_valid  = !w_empty && (!w_head_cfg || r_drain);
    assign w_pop      = w_q_valid && vec_ready_i;

    assign inst_ready_o = !flush_i && ((r_count != C_DEPTH) || w_pop);
    assign w_accept     = inst_valid_i && inst_ready_o;
    assign w_is_vec     = (inst_i[6:0] == V_ARITH);
    assign w_is_cfg     = (inst_i[14:12] == CONF);

`ifdef VEC_ISSUE_BYPASS_EN
    assign w_bypass = w_accept && w_is_vec && !w_is_cfg && w_empty && vec_ready_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = w_accept && w_is_vec && !w_bypass;
    assign w_wr_entry = '{inst: inst_i, rs1: rs1_i, rs2: rs2_i, is_cfg: w_is_cfg};

    vec_issue_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_tail),
        .wdata (w_wr_entry),
        .raddr (r_head),
        .rdata (w_head_entry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_cfg_cnt <= '0;
            r_reject  <= 1'b0;
            r_drain   <= 1'b0;
        end else if (flush_i) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_cfg_cnt <= '0;
            r_reject  <= 1'b0;
            r_drain   <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_cfg_cnt <= r_cfg_cnt + CNT_W'(w_push && w_is_cfg) - CNT_W'(w_pop && w_head_cfg);
            r_reject  <= w_accept && !w_is_vec;
            // Once armed the flag holds, so a presented config head stays valid.
            r_drain   <= w_head_cfg && !w_pop && (vec_ready_i || r_drain);
        end
    end

    assign vec_valid_o   = w_q_valid || w_bypass;
    assign reject_o      = r_reject;
    assign count_o       = r_count;
    assign cfg_pending_o = (r_cfg_cnt != '0);

    always_comb begin
        vec_inst_o = '0;
        rs1_o      = '0;
        rs2_o      = '0;
        if (w_bypass) begin
            vec_inst_o = inst_i;
            rs1_o      = rs1_i;
            rs2_o      = rs2_i;
        end else if (!w_empty) begin
            vec_inst_o = w_head_entry.inst;
            rs1_o      = w_head_entry.rs1;
            rs2_o      = w_head_entry.rs2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vec_issue_queue : scoreboard bench for vec_issue_queue             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_vec_issue_queue;

    localparam logic [31:0] VADD  = 32'h02208057;
    localparam logic [31:0] ADDI  = 32'h00000013;
    localparam logic [31:0] VSETV = 32'h00807057;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inst_valid, vec_ready, flush;
    logic [31:0] inst, rs1, rs2;
    logic        inst_ready_o, vec_valid_o, reject_o, cfg_pending_o;
    logic [31:0] vec_inst_o, rs1_o, rs2_o;
    logic [2:0]  count_o;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vec_issue_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .inst_valid_i  (inst_valid),
        .inst_i        (inst),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .inst_ready_o  (inst_ready_o),
        .vec_valid_o   (vec_valid_o),
        .vec_inst_o    (vec_inst_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .vec_ready_i   (vec_ready),
        .flush_i       (flush),
        .reject_o      (reject_o),
        .count_o       (count_o),
        .cfg_pending_o (cfg_pending_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every consumed head is compared against the scoreboard front.
    always @(negedge clk) begin
        if (reset_n && vec_valid_o && vec_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%h required=none", vec_inst_o);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_inst", vec_inst_o, mon_e.inst);
                chk("pop_rs1", rs1_o, mon_e.rs1);
                chk("pop_rs2", rs2_o, mon_e.rs2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_rdy, input string nm);
        logic [6:0] op;
        inst_valid = 1'b1;
        inst = ins;
        rs1 = a;
        rs2 = b;
        op = ins[6:0];
        @(negedge clk);
        chk(nm, inst_ready_o, exp_rdy);
        if (exp_rdy && op == 7'h57) sb.push_back('{ins, a, b});
        step();
        inst_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        vec_ready = 1'b1;
        while (count_o != 0 && n < 20) begin
            step();
            n++;
        end
        vec_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_count"}, count_o, 0);
        chk({nm, "_vinst"}, vec_inst_o, 0);
        chk({nm, "_sb"}, sb.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int expv[4];
        reset_n = 1'b0; inst_valid = 1'b0; vec_ready = 1'b0; flush = 1'b0;
        inst = '0; rs1 = '0; rs2 = '0;
        #13;
        chk("rst_count", count_o, 0);
        chk("rst_valid", vec_valid_o, 0);
        chk("rst_reject", reject_o, 0);
        chk("rst_cfg", cfg_pending_o, 0);
        chk("rst_vinst", vec_inst_o, 0);
        reset_n = 1'b1;
        step();
        chk("post_rst_ready", inst_ready_o, 1);

        // Fill: four accepted, fifth stalls.
        for (int i = 0; i < 5; i++) begin
            offer(VADD, i, 32'h100 + i, (i < 4), "fill_ready");
            chk("fill_count", count_o, (i < 4) ? i + 1 : 4);
        end
        chk("full_vinst", vec_inst_o, VADD);
        chk("full_rs1", rs1_o, 0);

        // Full with simultaneous pop.
        vec_ready = 1'b1;
        offer(VADD, 5, 32'h105, 1'b1, "full_pop_ready");
        vec_ready = 1'b0;
        chk("full_pop_count", count_o, 4);
        drain("drain1");

        // Reject of a non-vector word.
        offer(VADD, 7, 32'h107, 1'b1, "rej_vec_ready");
        chk("rej_before", reject_o, 0);
        offer(ADDI, 8, 32'h108, 1'b1, "rej_ready");
        chk("rej_pulse", reject_o, 1);
        chk("rej_count", count_o, 1);
        step();
        chk("rej_clear", reject_o, 0);
        chk("rej_count2", count_o, 1);
        drain("drain2");

        // Config entry behind two arith ops: one bubble before it is presented.
        offer(VADD, 21, 32'h121, 1'b1, "cfg_a");
        offer(VADD, 22, 32'h122, 1'b1, "cfg_b");
        offer(VSETV, 23, 32'h123, 1'b1, "cfg_c");
        chk("cfg_count", count_o, 3);
        chk("cfg_pend_set", cfg_pending_o, 1);
        expv[0] = 1; expv[1] = 1; expv[2] = 0; expv[3] = 1;
        vec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cfg_valid", vec_valid_o, expv[k]);
            chk("cfg_pend", cfg_pending_o, 1);
            step();
        end
        vec_ready = 1'b0;
        chk("cfg_pend_clr", cfg_pending_o, 0);
        chk("cfg_empty", count_o, 0);
        chk("cfg_sb", sb.size(), 0);

        // Flush with three entries, one of them config.
        offer(VADD, 31, 32'h131, 1'b1, "fl_a");
        offer(VSETV, 32, 32'h132, 1'b1, "fl_b");
        offer(VADD, 33, 32'h133, 1'b1, "fl_c");
        chk("fl_count3", count_o, 3);
        flush = 1'b1;
        inst_valid = 1'b1; inst = VADD;
        @(negedge clk);
        chk("fl_ready_low", inst_ready_o, 0);
        step();
        flush = 1'b0;
        inst_valid = 1'b0;
        sb.delete();
        chk("fl_count", count_o, 0);
        chk("fl_valid", vec_valid_o, 0);
        chk("fl_cfg", cfg_pending_o, 0);
        chk("fl_vinst", vec_inst_o, 0);

        // Asynchronous reset between edges with three entries.
        offer(VADD, 41, 32'h141, 1'b1, "ar_a");
        offer(VSETV, 42, 32'h142, 1'b1, "ar_b");
        offer(VADD, 43, 32'h143, 1'b1, "ar_c");
        chk("ar_count3", count_o, 3);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("ar_count", count_o, 0);
        chk("ar_valid", vec_valid_o, 0);
        chk("ar_cfg", cfg_pending_o, 0);
        chk("ar_reject", reject_o, 0);
        chk("ar_vinst", vec_inst_o, 0);
        chk("ar_rs1", rs1_o, 0);
        chk("ar_rs2", rs2_o, 0);
        #4;
        reset_n = 1'b1;
        step();
        chk("ar_ready", inst_ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
